// File: rtl/iagc_pkg.sv
// Shared IAGC definitions: status encodings, serial receiver FSM states and
// default baud divisor for the 100 MHz / 115200 host line.
package iagc_pkg;

   typedef enum logic [3:0] {
      IAGC_RESET     = 4'b0000,
      IAGC_CLEAN_MEM = 4'b1000
   } iagc_status_e;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_WAIT_HIGH
   } rx_state_e;

   localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/cmd_uart_rx_if.sv
// Command-word bundle from the serial receiver to the IAGC command unit.
interface cmd_uart_rx_if #(
   parameter int unsigned DATA_SIZE = 8
);
   logic [DATA_SIZE-1:0] o_cmd;
   logic                 o_cmd_valid;
   logic                 o_frame_error;
   logic                 o_parity_error;
   logic                 o_busy;

   modport master (
      output o_cmd, o_cmd_valid, o_frame_error, o_parity_error, o_busy
   );

   modport slave (
      input  o_cmd, o_cmd_valid, o_frame_error, o_parity_error, o_busy
   );
endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs; flops preset to
// RESET_VAL so the output is well defined straight out of reset.
module sync_2ff #(
   parameter int unsigned          WIDTH     = 1,
   parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
   input  logic             i_clock,
   input  logic             i_reset_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);
   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;
endmodule

// File: rtl/cmd_uart_rx.sv
// Serial command receiver: 8N1 (or 8E1 with CMD_UART_RX_PARITY_EN defined)
// frames from the host line, delivered as command words with a valid strobe.
module cmd_uart_rx
   import iagc_pkg::*;
#(
   parameter int unsigned DATA_SIZE    = 8,
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic           i_clock,
   input  logic           i_reset_n,
   input  logic           i_rx,
   cmd_uart_rx_if.master  if_cmd
);
   localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W  = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_SIZE - 1);

   logic                 w_rx_s;
   rx_state_e            r_state,  w_state_nx;
   logic [BAUD_W-1:0]    r_baud,   w_baud_nx, w_baud_inc;
   logic                 w_baud_end;
   logic [BIT_W-1:0]     r_bitcnt, w_bitcnt_nx;
   logic [DATA_SIZE-1:0] r_shift,  w_shift_nx;
   logic [DATA_SIZE-1:0] r_cmd,    w_cmd_nx;
   logic                 r_cmd_valid, w_cmd_valid_nx;
   logic                 r_frame_err, w_frame_err_nx;
`ifdef CMD_UART_RX_PARITY_EN
   logic                 r_par_fault, w_par_fault_nx;
   logic                 r_par_err,   w_par_err_nx;
`endif

   sync_2ff #(
      .WIDTH     (1),
      .RESET_VAL (1'b1)
   ) u_sync_rx (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .i_d       (i_rx),
      .o_q       (w_rx_s)
   );

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state     <= RX_IDLE;
         r_baud      <= '0;
         r_bitcnt    <= '0;
         r_shift     <= '0;
         r_cmd       <= '0;
         r_cmd_valid <= 1'b0;
         r_frame_err <= 1'b0;
`ifdef CMD_UART_RX_PARITY_EN
         r_par_fault <= 1'b0;
         r_par_err   <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_nx;
         r_baud      <= w_baud_nx;
         r_bitcnt    <= w_bitcnt_nx;
         r_shift     <= w_shift_nx;
         r_cmd       <= w_cmd_nx;
         r_cmd_valid <= w_cmd_valid_nx;
         r_frame_err <= w_frame_err_nx;
`ifdef CMD_UART_RX_PARITY_EN
         r_par_fault <= w_par_fault_nx;
         r_par_err   <= w_par_err_nx;
`endif
      end
   end

   always_comb begin
      w_state_nx     = r_state;
      w_baud_nx      = r_baud;
      w_bitcnt_nx    = r_bitcnt;
      w_shift_nx     = r_shift;
      w_cmd_nx       = r_cmd;
      w_cmd_valid_nx = 1'b0;
      w_frame_err_nx = 1'b0;
`ifdef CMD_UART_RX_PARITY_EN
      w_par_fault_nx = r_par_fault;
      w_par_err_nx   = 1'b0;
`endif
      w_baud_end = (r_baud == BAUD_LAST);
      w_baud_inc = w_baud_end ? '0 : r_baud + 1'b1;

      case (r_state)
         RX_IDLE: begin
            w_baud_nx = '0;
            if (!w_rx_s) begin
               w_state_nx  = RX_START;
               w_bitcnt_nx = '0;
`ifdef CMD_UART_RX_PARITY_EN
               w_par_fault_nx = 1'b0;
`endif
            end
         end

         // Mid-start check; a line that is already high again was a glitch.
         RX_START: begin
            if (r_baud == BAUD_HALF) begin
               w_baud_nx  = '0;
               w_state_nx = w_rx_s ? RX_IDLE : RX_DATA;
            end else begin
               w_baud_nx = w_baud_inc;
            end
         end

         RX_DATA: begin
            w_baud_nx = w_baud_inc;
            if (w_baud_end) begin
               w_shift_nx                = r_shift >> 1;
               w_shift_nx[DATA_SIZE-1]   = w_rx_s;
               w_bitcnt_nx               = r_bitcnt + 1'b1;
               if (r_bitcnt == BIT_LAST) begin
`ifdef CMD_UART_RX_PARITY_EN
                  w_state_nx = RX_PARITY;
`else
                  w_state_nx = RX_STOP;
`endif
               end
            end
         end

`ifdef CMD_UART_RX_PARITY_EN
         RX_PARITY: begin
            w_baud_nx = w_baud_inc;
            if (w_baud_end) begin
               w_par_fault_nx = (w_rx_s != ^r_shift);
               w_state_nx     = RX_STOP;
            end
         end
`endif

         RX_STOP: begin
            w_baud_nx = w_baud_inc;
            if (w_baud_end) begin
               if (w_rx_s) begin
                  w_state_nx = RX_IDLE;
`ifdef CMD_UART_RX_PARITY_EN
                  if (r_par_fault) begin
                     w_par_err_nx = 1'b1;
                  end else begin
                     w_cmd_nx       = r_shift;
                     w_cmd_valid_nx = 1'b1;
                  end
`else
                  w_cmd_nx       = r_shift;
                  w_cmd_valid_nx = 1'b1;
`endif
               end else begin
                  w_frame_err_nx = 1'b1;
                  w_state_nx     = RX_WAIT_HIGH;
               end
            end
         end

         // Hold off after a low stop bit so a break is not taken as a start.
         RX_WAIT_HIGH: begin
            w_baud_nx = '0;
            if (w_rx_s) w_state_nx = RX_IDLE;
         end

         default: begin
            w_baud_nx  = '0;
            w_state_nx = RX_IDLE;
         end
      endcase
   end

   assign if_cmd.o_cmd         = r_cmd;
   assign if_cmd.o_cmd_valid   = r_cmd_valid;
   assign if_cmd.o_frame_error = r_frame_err;
   assign if_cmd.o_busy        = (r_state != RX_IDLE);
`ifdef CMD_UART_RX_PARITY_EN
   assign if_cmd.o_parity_error = r_par_err;
`else
   assign if_cmd.o_parity_error = 1'b0;
`endif
endmodule

// File: tb/tb_cmd_uart_rx.sv
// Directed bench for cmd_uart_rx at CLKS_PER_BIT = 4 with a command scoreboard.
module tb_cmd_uart_rx;
   localparam int CPB = 4;
`ifdef CMD_UART_RX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif

   logic clk;
   logic rst_n;
   logic rx;

   int n_checks = 0;
   int n_errors = 0;
   int n_valid  = 0;
   int n_ferr   = 0;
   int n_perr   = 0;
   logic [7:0] sb[$];

   cmd_uart_rx_if #(.DATA_SIZE(8)) u_if ();

   cmd_uart_rx #(
      .DATA_SIZE    (8),
      .CLKS_PER_BIT (CPB)
   ) u_dut (
      .i_clock   (clk),
      .i_reset_n (rst_n),
      .i_rx      (rx),
      .if_cmd    (u_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par_ok, input logic stop);
      logic pbit;
      pbit = (^d) ^ ~par_ok;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef CMD_UART_RX_PARITY_EN
      drive_bit(pbit);
`endif
      drive_bit(stop);
   endtask

   // Scoreboard side: every delivered command must match the oldest pushed frame.
   always @(negedge clk) begin
      if (rst_n) begin
         if (u_if.o_cmd_valid || u_if.o_frame_error || u_if.o_parity_error)
            check("pulse_onehot",
                  32'($onehot0({u_if.o_cmd_valid, u_if.o_frame_error, u_if.o_parity_error})),
                  32'd1);
         if (u_if.o_cmd_valid) begin
            logic [31:0] exp;
            n_valid++;
            exp = (sb.size() > 0) ? 32'(sb.pop_front()) : 32'hFFFF_FFFF;
            check("sb_cmd", 32'(u_if.o_cmd), exp);
         end
         if (u_if.o_frame_error)  n_ferr++;
         if (u_if.o_parity_error) n_perr++;
      end
   end

   initial begin
      rst_n = 1'b0;
      rx    = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_cmd",   32'(u_if.o_cmd), 32'h0);
      check("rst_valid", 32'(u_if.o_cmd_valid), 32'h0);
      check("rst_ferr",  32'(u_if.o_frame_error), 32'h0);
      check("rst_perr",  32'(u_if.o_parity_error), 32'h0);
      check("rst_busy",  32'(u_if.o_busy), 32'h0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Single frame with pulse timing relative to the stop mid-sample
      sb.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, 1'b1);
      check("a5_valid_early", 32'(u_if.o_cmd_valid), 32'h0);
      @(negedge clk);
      check("a5_valid", 32'(u_if.o_cmd_valid), 32'h1);
      check("a5_cmd",   32'(u_if.o_cmd), 32'hA5);
      @(negedge clk);
      check("a5_valid_width", 32'(u_if.o_cmd_valid), 32'h0);
      repeat (4) @(negedge clk);
      check("a5_busy_after", 32'(u_if.o_busy), 32'h0);
      check("a5_nvalid", 32'(n_valid), 32'd1);

      // Back-to-back frames with no idle gap
      sb.push_back(8'h3C);
      sb.push_back(8'hC3);
      send_frame(8'h3C, 1'b1, 1'b1);
      send_frame(8'hC3, 1'b1, 1'b1);
      repeat (8) @(negedge clk);
      check("b2b_nvalid", 32'(n_valid), 32'd3);
      check("b2b_cmd",    32'(u_if.o_cmd), 32'hC3);
      check("b2b_busy",   32'(u_if.o_busy), 32'h0);

      // One-cycle low glitch is rejected at the start mid-sample
      rx = 1'b0;
      @(negedge clk);
      rx = 1'b1;
      repeat (2) @(negedge clk);
      check("glitch_busy_high", 32'(u_if.o_busy), 32'h1);
      repeat (3) @(negedge clk);
      check("glitch_busy_low", 32'(u_if.o_busy), 32'h0);
      repeat (10) @(negedge clk);
      check("glitch_nvalid", 32'(n_valid), 32'd3);
      check("glitch_nferr",  32'(n_ferr), 32'd0);

      // Low stop bit followed by a held-low line
      send_frame(8'h12, 1'b1, 1'b0);
      repeat (20) @(negedge clk);
      check("ferr_count",  32'(n_ferr), 32'd1);
      check("ferr_cmd",    32'(u_if.o_cmd), 32'hC3);
      check("ferr_nvalid", 32'(n_valid), 32'd3);
      check("ferr_wait",   32'(u_if.o_busy), 32'h1);
      rx = 1'b1;
      repeat (5) @(negedge clk);
      check("ferr_idle", 32'(u_if.o_busy), 32'h0);
      check("ferr_nperr", 32'(n_perr), 32'd0);

      // Reset during the 4th data bit of 0xFF
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      drive_bit(1'b1);
      rx = 1'b1;
      repeat (2) @(negedge clk);
      check("mid_busy", 32'(u_if.o_busy), 32'h1);
      rst_n = 1'b0;
      #1;
      check("mrst_cmd",   32'(u_if.o_cmd), 32'h0);
      check("mrst_valid", 32'(u_if.o_cmd_valid), 32'h0);
      check("mrst_ferr",  32'(u_if.o_frame_error), 32'h0);
      check("mrst_perr",  32'(u_if.o_parity_error), 32'h0);
      check("mrst_busy",  32'(u_if.o_busy), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      sb.push_back(8'h81);
      send_frame(8'h81, 1'b1, 1'b1);
      repeat (6) @(negedge clk);
      check("post_rst_cmd",    32'(u_if.o_cmd), 32'h81);
      check("post_rst_nvalid", 32'(n_valid), 32'd4);

`ifdef CMD_UART_RX_PARITY_EN
      send_frame(8'h07, 1'b0, 1'b1);
      repeat (6) @(negedge clk);
      check("par_bad_nperr",  32'(n_perr), 32'd1);
      check("par_bad_nvalid", 32'(n_valid), 32'd4);
      check("par_bad_cmd",    32'(u_if.o_cmd), 32'h81);
      sb.push_back(8'h07);
      send_frame(8'h07, 1'b1, 1'b1);
      repeat (6) @(negedge clk);
      check("par_ok_nvalid", 32'(n_valid), 32'd5);
      check("par_ok_cmd",    32'(u_if.o_cmd), 32'h07);
      check("par_ok_nperr",  32'(n_perr), 32'd1);
`else
      check("nopar_nperr", 32'(n_perr), 32'd0);
`endif

      check("frame_bits_used", 32'(FRAME_BITS), 32'(FRAME_BITS));
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
